rr_resource_arbiter: RTL and testbench
======================================

// Module: rr_resource_arbiter
//
// PURPOSE
// - Round-robin arbiter that shares one DUT-side resource (bus, engine port) among N_REQ requesters.
// - A requester that wins keeps ownership across many cycles. It gives ownership back with an explicit release pulse.
// - Sits between requester agents and the shared datapath. gnt_id drives the resource's input mux select.
//
// PARAMETERS
// - N_REQ     4    number of requesters, >= 2
// - MAX_HOLD  255  watchdog limit, in cycles of continuous ownership (used only with ARB_WDOG_EN), >= 1
// - ID_W      $clog2(N_REQ)  width of gnt_id (localparam, derived)
//
// PORTS
// - clk      in   1      single clock, rising edge
// - rst      in   1      synchronous reset, active-high
// - req      in   N_REQ  request level per requester
// - rel      in   N_REQ  release pulse per requester; only the current owner's bit is honoured
// - gnt      out  N_REQ  one-hot grant, registered
// - gnt_vld  out  1      high while any grant is held (equals |gnt)
// - gnt_id   out  ID_W   binary index of owner; 0 when gnt_vld=0
// - wdog_to  out  1      one-cycle pulse on watchdog forced release; tied 0 without ARB_WDOG_EN
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge)
//   - gnt=0, gnt_vld=0, gnt_id=0, wdog_to=0, state=IDLE.
//   - RR pointer ptr=0; hold counter=0.
//   - Reset mid-grant drops the grant at that edge. No release handshake occurs.
// - State machine: two states, IDLE and OWN.
// - IDLE
//   - If req!=0 at edge k, pick the first set bit searching ptr, ptr+1, ... mod N_REQ.
//   - After edge k: gnt=onehot(winner), gnt_id=winner, state=OWN.
//   - Latency from req sampled to gnt visible is 1 cycle.
//   - If req==0, remain in IDLE with all outputs 0.
// - OWN
//   - The grant is held regardless of req. Deasserting req does not release.
//   - rel[owner]=1 at an edge: after that edge gnt=0, state=IDLE, ptr=(owner+1) mod N_REQ.
//   - rel bits of non-owners are ignored in every state. rel in IDLE is ignored.
//   - A release always forces at least one IDLE cycle with gnt=0. The minimum gap between two grants is exactly 1 cycle.
//   - Simultaneous rel[owner] and req[owner]: the release takes effect. The owner re-competes from IDLE at the lowest priority (ptr is past it).
// - Fairness
//   - Each requester with req held continuously is granted within N_REQ-1 other ownerships.
// - Invariants
//   - gnt is always one-hot or zero.
//   - gnt_id is stable for the whole ownership.
//   - No combinational path from req/rel to any output.
//
// CONFIGURATION
// - Macro ARB_WDOG_EN.
// - Defined
//   - The hold counter clears on entry to OWN and increments every cycle in OWN.
//   - When it reaches MAX_HOLD without rel[owner], the arbiter performs the same transition as a release at that edge: gnt=0, ptr=owner+1.
//   - wdog_to=1 for exactly the following cycle.
//   - rel[owner] on the same edge as the timeout counts as a normal release. wdog_to stays 0.
// - Not defined
//   - No counter logic is synthesised. Ownership is unlimited and wdog_to is constant 0.
//
// TESTING
// - N_REQ=4, reset, req=4'b1010 -> next cycle gnt=4'b0010, gnt_id=1. Hold 20 cycles with no rel -> grant unchanged.
// - Same state, pulse rel[1] -> gnt=0 for 1 cycle, then gnt=4'b1000, gnt_id=3.
// - req=4'b1111 held, each owner pulses rel 3 cycles after grant -> grant order 0,1,2,3,0 with a 1-cycle gap each time.
// - Owner 2 holding, pulse rel[0] and rel[3], deassert req[2] -> gnt=4'b0100 unchanged.
// - Owner 1 holding, assert rst for 1 cycle -> gnt=0, gnt_id=0. After rst, req=4'b1111 -> owner 0 (ptr reset).
// - ARB_WDOG_EN, MAX_HOLD=8, owner 0 never releases -> grant drops 8 cycles after it was given, wdog_to pulses 1 cycle, next owner is 1.

Source files
------------

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared resource to N_REQ requesters with
// ownership held until the owner pulses release. Optional watchdog: ARB_WDOG_EN.
module rr_resource_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 255,
  localparam int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] rel_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_vld_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             wdog_to_o
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  if (N_REQ < 2) begin : g_chk_n
    $error("rr_resource_arbiter: N_REQ must be >= 2");
  end
  if (MAX_HOLD < 1) begin : g_chk_hold
    $error("rr_resource_arbiter: MAX_HOLD must be >= 1");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               vld_q, vld_d;

  logic               found;
  logic [ID_W-1:0]    win;
  int unsigned        idx;
  logic               rel_own;
  logic               timeout;
  logic [ID_W-1:0]    ptr_nxt;

  assign rel_own = rel_i[id_q];
  assign ptr_nxt = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

  // Rotating search: first set request starting at ptr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          gnt_d   = N_REQ'(1) << win;
          id_d    = win;
          vld_d   = 1'b1;
        end
      end
      OWN: begin
        if (rel_own || timeout) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          vld_d   = 1'b0;
          ptr_d   = ptr_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_WDOG_EN
  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wdog_q;

  // cnt_q counts completed OWN cycles; the MAX_HOLD-th one forces release.
  assign timeout = (state_q == OWN) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != OWN) begin
      cnt_d = '0;
    end else if (!timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= timeout && !rel_own;
    end
  end

  assign wdog_to_o = wdog_q;
`else
  assign timeout   = 1'b0;
  assign wdog_to_o = 1'b0;
`endif

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = vld_q;
  assign gnt_id_o  = id_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(gnt_q) && (vld_q == (|gnt_q)))
        else $error("rr_resource_arbiter: grant not one-hot/zero or vld inconsistent");
    end
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Scoreboard bench for rr_resource_arbiter: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural ownership model.
module tb_rr_resource_arbiter;

  localparam int N = 4;
  localparam int MAXH = 8;
`ifdef ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
  localparam int HOLD_CYC = 5;
`else
  localparam bit WDOG = 1'b0;
  localparam int HOLD_CYC = 20;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       wd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       wdog_to;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_resource_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .rel_i     (rel),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id),
    .wdog_to_o (wdog_to)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int unsigned act, int unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endfunction

  // Ownership model: who holds the resource after the coming edge.
  function automatic void model(logic r, logic [3:0] q, logic [3:0] l);
    exp_t e;
    bool_found: begin end
    e = '0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && q[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_hold  = 0;
        end
      end
    end else begin
      m_hold++;
      if (l[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (WDOG && m_hold >= MAXH) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        e.wd    = 1'b1;
      end
    end
    if (m_owner >= 0) begin
      e.gnt = 4'b0001 << m_owner;
      e.id  = m_owner[1:0];
      e.vld = 1'b1;
    end
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l);
    @(negedge clk);
    rst = r;
    req = q;
    rel = l;
    model(r, q, l);
  endtask

  task automatic expect_now(string name, logic [3:0] g, logic [1:0] id);
    chk({name, "_gnt"}, gnt, g);
    chk({name, "_id"}, gnt_id, id);
  endtask

  // Monitor: every output cycle is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", {gnt, gnt_id, gnt_vld, wdog_to}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] order [5];
    logic [3:0] rq, rl;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    // Reset state.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    expect_now("reset", 4'b0000, 2'd0);

    // Grant to 1 from 1010, held with no release.
    step(1'b0, 4'b1010, 4'b0000);
    step(1'b0, 4'b1010, 4'b0000);
    expect_now("first_grant", 4'b0010, 2'd1);
    for (int i = 0; i < HOLD_CYC; i++) step(1'b0, 4'b1010, 4'b0000);
    expect_now("held", 4'b0010, 2'd1);
    step(1'b0, 4'b1010, 4'b0010);
    step(1'b0, 4'b1010, 4'b0000);
    expect_now("rel_gap", 4'b0000, 2'd0);
    step(1'b0, 4'b1010, 4'b0000);
    expect_now("next_owner3", 4'b1000, 2'd3);
    step(1'b0, 4'b0000, 4'b1000);
    step(1'b0, 4'b0000, 4'b0000);

    // All requesting: rotation 0,1,2,3,0 with one-cycle gaps.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 4'b0000);
      expect_now("rotation", 4'b0001 << order[k], order[k][1:0]);
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b1111, 4'b0001 << order[k]);
      step(1'b0, 4'b1111, 4'b0000);
      expect_now("rotation_gap", 4'b0000, 2'd0);
    end

    // Owner 2 ignores foreign releases and its own req dropping.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0000, 4'b1001);
    step(1'b0, 4'b0000, 4'b0000);
    expect_now("foreign_rel", 4'b0100, 2'd2);
    step(1'b0, 4'b0000, 4'b0100);
    step(1'b0, 4'b0000, 4'b0000);

    // Reset mid-grant, then pointer restarts at 0.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0010, 4'b0000);
    step(1'b0, 4'b0010, 4'b0000);
    expect_now("pre_rst", 4'b0010, 2'd1);
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    expect_now("mid_rst", 4'b0000, 2'd0);
    step(1'b0, 4'b1111, 4'b0000);
    expect_now("post_rst", 4'b0001, 2'd0);
    step(1'b0, 4'b0000, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000);

`ifdef ARB_WDOG_EN
    // Owner 0 never releases: forced drop after MAXH cycles, then owner 1.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0011, 4'b0000);
    step(1'b0, 4'b0011, 4'b0000);
    expect_now("wd_grant", 4'b0001, 2'd0);
    for (int i = 1; i < MAXH; i++) step(1'b0, 4'b0011, 4'b0000);
    expect_now("wd_last", 4'b0001, 2'd0);
    step(1'b0, 4'b0011, 4'b0000);
    expect_now("wd_drop", 4'b0000, 2'd0);
    chk("wd_pulse", wdog_to, 1);
    step(1'b0, 4'b0011, 4'b0000);
    expect_now("wd_next", 4'b0010, 2'd1);
    chk("wd_pulse_end", wdog_to, 0);
    step(1'b0, 4'b0000, 4'b0010);
`endif

    // Random traffic with occasional resets and owner/non-owner releases.
    for (int c = 0; c < 3000; c++) begin
      rq = 4'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 99) == 0), rq, rl);
    end
    step(1'b0, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
